// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Each stage sums one WIDTH/STAGES slice,
// LSB slice first, with the slice carry registered into the next stage.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero
);

    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;

    generate
        if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0 || (SW % GROUP) != 0) begin : g_param_check
            $error("pipelined_cla_addsub: WIDTH must split into STAGES (1..8) slices that are multiples of GROUP");
        end
    endgenerate

    // Returns carries {c[SW], ..., c[1], ci}; every carry is a flat sum-of-products
    // over group P/G terms, so there is no ripple between groups.
    function automatic logic [SW:0] cla_carries(input logic [SW-1:0] p, input logic [SW-1:0] g,
                                                input logic ci);
        logic [NG-1:0] gp;
        logic [NG-1:0] gg;
        logic [NG:0]   gc;
        logic [SW:0]   c;
        logic          t;
        gp = '0;
        gg = '0;
        gc = '0;
        c  = '0;
        for (int unsigned j = 0; j < NG; j++) begin
            gp[j] = &p[j*GROUP +: GROUP];
            for (int unsigned m = 0; m < GROUP; m++) begin
                t = g[j*GROUP+m];
                for (int unsigned n = m + 1; n < GROUP; n++) t = t & p[j*GROUP+n];
                gg[j] = gg[j] | t;
            end
        end
        gc[0] = ci;
        for (int unsigned j = 1; j <= NG; j++) begin
            for (int unsigned m = 0; m <= j; m++) begin
                if (m == 0) t = ci;
                else        t = gg[m-1];
                for (int unsigned n = m; n < j; n++) t = t & gp[n];
                gc[j] = gc[j] | t;
            end
        end
        c[0] = ci;
        for (int unsigned j = 0; j < NG; j++) begin
            for (int unsigned i = 0; i + 1 < GROUP; i++) begin
                for (int unsigned m = 0; m <= i + 1; m++) begin
                    if (m == 0) t = gc[j];
                    else        t = g[j*GROUP+m-1];
                    for (int unsigned n = m; n <= i; n++) t = t & p[j*GROUP+n];
                    c[j*GROUP+i+1] = c[j*GROUP+i+1] | t;
                end
            end
            c[j*GROUP+GROUP] = gc[j+1];
        end
        return c;
    endfunction

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;
    logic             zero_q;

    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] b_i [STAGES];
    logic [WIDTH-1:0] s_i [STAGES];
    logic             c_i [STAGES];
    logic             v_i [STAGES];
    logic [SW-1:0]    p   [STAGES];
    logic [SW-1:0]    g   [STAGES];
    logic [SW:0]      cx  [STAGES];
    logic [WIDTH-1:0] a_n [STAGES];
    logic [WIDTH-1:0] b_n [STAGES];
    logic [WIDTH-1:0] s_n [STAGES];
    logic             c_n [STAGES];
    logic             ovf_n;
    logic             zero_n;
    logic             advance;

    assign advance   = !v_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign Result    = s_q[STAGES-1];
    assign Cout      = c_q[STAGES-1];
    assign Overflow  = ovf_q;
    assign Zero      = zero_q;

    // Operands shift right one slice per stage; finished sum slices enter the
    // sum word from the top, so the last stage holds the full result in place.
    always_comb begin
        a_i[0] = operand1;
        b_i[0] = sub ? ~operand2 : operand2;
        c_i[0] = sub ? ~cin : cin;
        v_i[0] = in_valid;
        s_i[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_i[k] = a_q[k-1];
            b_i[k] = b_q[k-1];
            c_i[k] = c_q[k-1];
            v_i[k] = v_q[k-1];
            s_i[k] = s_q[k-1];
        end
        ovf_n = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            p[k]   = a_i[k][SW-1:0] ^ b_i[k][SW-1:0];
            g[k]   = a_i[k][SW-1:0] & b_i[k][SW-1:0];
            cx[k]  = cla_carries(p[k], g[k], c_i[k]);
            a_n[k] = a_i[k] >> SW;
            b_n[k] = b_i[k] >> SW;
            s_n[k] = (s_i[k] >> SW) | (WIDTH'(p[k] ^ cx[k][SW-1:0]) << (WIDTH - SW));
            c_n[k] = cx[k][SW];
            if (k == STAGES - 1) ovf_n = cx[k][SW] ^ cx[k][SW-1];
        end
        zero_n = (s_n[STAGES-1] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_n[k];
                b_q[k] <= b_n[k];
                s_q[k] <= s_n[k];
                c_q[k] <= c_n[k];
                v_q[k] <= v_i[k];
            end
            ovf_q  <= ovf_n;
            zero_q <= zero_n;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed corner cases on the default build, then
// randomized streams on three parameter sets checked against an arithmetic model.
module tb_pipelined_cla_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] op1, op2;
    logic        cin, sub;
    logic        iv [3];
    logic        ordy [3];
    logic        irdy [3];
    logic        ovld [3];
    logic        cout [3];
    logic        ovf [3];
    logic        zf [3];
    logic [31:0] r0;
    logic [15:0] r1;
    logic [63:0] r2;
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(32), .STAGES(2), .GROUP(4)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .operand1(op1[31:0]), .operand2(op2[31:0]), .cin(cin), .sub(sub),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .Result(r0), .Cout(cout[0]),
        .Overflow(ovf[0]), .Zero(zf[0]));

    pipelined_cla_addsub #(.WIDTH(16), .STAGES(1), .GROUP(4)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .operand1(op1[15:0]), .operand2(op2[15:0]), .cin(cin), .sub(sub),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .Result(r1), .Cout(cout[1]),
        .Overflow(ovf[1]), .Zero(zf[1]));

    pipelined_cla_addsub #(.WIDTH(64), .STAGES(4), .GROUP(8)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .operand1(op1), .operand2(op2), .cin(cin), .sub(sub),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .Result(r2), .Cout(cout[2]),
        .Overflow(ovf[2]), .Zero(zf[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] get_res(input int idx);
        case (idx)
            0:       return {32'b0, r0};
            1:       return {48'b0, r1};
            default: return r2;
        endcase
    endfunction

    // Unbounded-integer reference: results wrap modulo 2^w, overflow means the
    // signed value falls outside the w-bit two's-complement range.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic ci,
                                  input logic sb, input int w, output logic [63:0] r,
                                  output logic c, output logic o, output logic z);
        logic [63:0]        m;
        logic [66:0]        ua, ub, tot, lim;
        logic signed [66:0] sa, sbv, s, smax, smin;
        m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua  = {3'b0, a & m};
        ub  = {3'b0, b & m};
        lim = 67'd1 << w;
        if (!sb) begin
            tot = ua + ub + 67'(ci);
            c   = (tot >= lim);
        end else begin
            tot = ua - ub - 67'(ci);
            c   = (ua >= ub + 67'(ci));
        end
        r  = tot[63:0] & m;
        sa = $signed(ua);
        if (ua[w-1]) sa = sa - $signed(lim);
        sbv = $signed(ub);
        if (ub[w-1]) sbv = sbv - $signed(lim);
        s    = sb ? (sa - sbv - $signed(67'(ci))) : (sa + sbv + $signed(67'(ci)));
        smax = $signed(lim >> 1) - 67'sd1;
        smin = -$signed(lim >> 1);
        o = (s > smax) || (s < smin);
        z = (r == 64'd0);
    endfunction

    task automatic send_check(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic ci, input logic sb, input logic [31:0] er,
                              input logic ec, input logic eo, input logic ez);
        @(negedge clk);
        op1 = {32'b0, a}; op2 = {32'b0, b}; cin = ci; sub = sb;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        #1 check({name, "_inready"}, irdy[0], 1);
        @(negedge clk);
        iv[0] = 1'b0;
        #1 check({name, "_early_valid"}, ovld[0], 0);
        @(negedge clk);
        #1;
        check({name, "_valid"}, ovld[0], 1);
        check({name, "_res"}, r0, er);
        check({name, "_cout"}, cout[0], ec);
        check({name, "_ovf"}, ovf[0], eo);
        check({name, "_zero"}, zf[0], ez);
    endtask

    task automatic run_random(input int idx, input int nbeats, input int w, input int stages);
        logic [63:0] qr [$];
        logic        qc [$], qo [$], qz [$];
        int          qa [$];
        logic [63:0] er;
        logic        ec, eo, ez;
        int          adv = 0, sent = 0, recv = 0;
        for (int cyc = 0; cyc < nbeats * 4 + 200 && recv < nbeats; cyc++) begin
            @(negedge clk);
            op1 = {$urandom, $urandom};
            op2 = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: op2 = ~op1;
                1: op2 = '1;
                2: op2 = '0;
                3: op1 = op2;
                default: ;
            endcase
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            iv[idx]   = (sent < nbeats) && ($urandom_range(0, 4) != 0);
            ordy[idx] = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_inready", irdy[idx], !ovld[idx] || ordy[idx]);
            if (ovld[idx]) begin
                if (qr.size() == 0) begin
                    check("rnd_spurious", ovld[idx], 0);
                end else if (ordy[idx]) begin
                    check("rnd_res", get_res(idx), qr.pop_front());
                    check("rnd_cout", cout[idx], qc.pop_front());
                    check("rnd_ovf", ovf[idx], qo.pop_front());
                    check("rnd_zero", zf[idx], qz.pop_front());
                    check("rnd_latency", adv - qa.pop_front(), stages);
                    recv++;
                end
            end
            if (iv[idx] && irdy[idx]) begin
                model(op1, op2, cin, sub, w, er, ec, eo, ez);
                qr.push_back(er); qc.push_back(ec); qo.push_back(eo); qz.push_back(ez);
                qa.push_back(adv);
                sent++;
            end
            if (irdy[idx]) adv++;
        end
        iv[idx] = 1'b0;
        ordy[idx] = 1'b1;
        check("rnd_drain", recv, nbeats);
    endtask

    initial begin
        int          sent, got;
        logic [31:0] held;
        logic        stalled;
        rst = 1'b0;
        op1 = '0; op2 = '0; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b1;
        end
        #1 rst = 1'b1;
        #3;
        check("reset_valid", ovld[0], 0);
        check("reset_res", r0, 0);
        check("reset_cout", cout[0], 0);
        check("reset_ovf", ovf[0], 0);
        check("reset_zero", zf[0], 0);
        check("reset_valid_w16", ovld[1], 0);
        check("reset_valid_w64", ovld[2], 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_inready", irdy[0], 1);

        send_check("add_cross", 32'h0000_FFFF, 32'h0000_0001, 0, 0, 32'h0001_0000, 0, 0, 0);
        send_check("sub_borrow", 32'h0000_0005, 32'h0000_0007, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
        send_check("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 0);
        send_check("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1);
        send_check("sub_ovf", 32'h8000_0000, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 1, 1, 0);
        send_check("sub_cin", 32'h0000_0000, 32'h0000_0000, 1, 1, 32'hFFFF_FFFF, 0, 0, 0);
        send_check("add_cin", 32'hFFFF_FFFE, 32'h0000_0001, 1, 0, 32'h0000_0000, 1, 0, 1);

        // Backpressure: out_ready low on cycles 3..5 of an 8-beat burst.
        sent = 0; got = 0; stalled = 1'b0; held = '0;
        for (int c = 1; c <= 40 && got < 8; c++) begin
            @(negedge clk);
            if (sent < 8) begin
                iv[0] = 1'b1;
                op1 = 64'(sent + 1);
                op2 = 64'(3 * (sent + 1));
                cin = 1'b0; sub = 1'b0;
            end else begin
                iv[0] = 1'b0;
            end
            ordy[0] = !(c >= 3 && c <= 5);
            #1;
            if (stalled) check("bp_hold", r0, held);
            if (ovld[0] && !ordy[0]) begin
                check("bp_inready", irdy[0], 0);
                held = r0;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (ovld[0] && ordy[0]) begin
                check("bp_res", r0, 64'(4 * (got + 1)));
                got++;
            end
            if (iv[0] && irdy[0]) sent++;
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        check("bp_count", got, 8);
        repeat (3) begin
            @(negedge clk);
            #1 check("bp_extra", ovld[0], 0);
        end

        // Asynchronous reset with two beats in flight.
        @(negedge clk);
        op1 = 64'd10; op2 = 64'd20; cin = 1'b0; sub = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        op1 = 64'd11; op2 = 64'd22;
        @(negedge clk);
        iv[0] = 1'b0;
        #1 check("rst_pre_valid", ovld[0], 1);
        #1 rst = 1'b1;
        #1;
        check("rst_valid", ovld[0], 0);
        check("rst_res", r0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_inready", irdy[0], 1);
        repeat (4) begin
            @(negedge clk);
            #1 check("rst_stale", ovld[0], 0);
        end
        send_check("post_rst", 32'd3, 32'd4, 0, 0, 32'd7, 0, 0, 0);

        run_random(0, 3000, 32, 2);
        run_random(1, 10000, 16, 1);
        run_random(2, 10000, 64, 4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
